// File: rtl/icache_l1.sv
// Direct-mapped L1 instruction cache with zero-cycle hits and in-order line refill.
// Miss costs BLOCKS memory handshakes; o_busy stalls fetch during refill and i_mem_ready paces it.
module icache_l1 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ELEMENTS   = 128,
  parameter int BLOCKS     = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rd,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic                  o_hit,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ready
);

  localparam int OFF_W = $clog2(BLOCKS);
  localparam int IDX_W = $clog2(ELEMENTS);
  localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(BLOCKS - 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic [1:0]       bsel;
  } addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ELEMENTS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [ELEMENTS];
  logic [DATA_WIDTH-1:0] r_data [ELEMENTS][BLOCKS];

  logic [TAG_W-1:0]   r_fill_tag;
  logic [IDX_W-1:0]   r_fill_idx;
  logic [OFF_W-1:0]   r_cnt;
  logic               r_flush_pend;

  addr_t              w_req;
  logic               w_tag_match;
  logic               w_lookup;
  logic               w_hit;
  logic               w_miss;
  logic               w_beat;
  logic               w_last;
  logic               w_unused;

  assign w_req       = addr_t'(i_addr);
  assign w_unused    = ^w_req.bsel;
  assign w_tag_match = r_valid[w_req.idx] && (r_tag[w_req.idx] == w_req.tag);
  assign w_lookup    = (r_state == IDLE) && i_rd && !i_flush;
  assign w_hit       = w_lookup && w_tag_match;
  assign w_miss      = w_lookup && !w_tag_match;
  assign w_beat      = (r_state == FILL) && i_mem_ready;
  assign w_last      = w_beat && (r_cnt == LAST_WORD);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_mem_rd    = 1'b0;
    o_mem_addr  = '0;
    o_hit       = 1'b0;
    o_inst      = '0;
    case (r_state)
      IDLE: begin
        o_hit = w_hit;
        if (w_hit) begin
          o_inst = r_data[w_req.idx][w_req.off];
        end
        if (w_miss) begin
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        o_busy     = 1'b1;
        o_mem_rd   = 1'b1;
        o_mem_addr = {r_fill_tag, r_fill_idx, r_cnt, 2'b00};
        if (w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A flush seen at any point of a refill (including the final beat) discards the line.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid      <= '0;
      r_fill_tag   <= '0;
      r_fill_idx   <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else if (r_state == IDLE) begin
      if (i_flush) begin
        r_valid <= '0;
      end else if (w_miss) begin
        r_fill_tag <= w_req.tag;
        r_fill_idx <= w_req.idx;
        r_cnt      <= '0;
      end
    end else begin
      if (i_flush) begin
        r_flush_pend <= 1'b1;
      end
      if (w_beat) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_flush_pend <= 1'b0;
        if (i_flush || r_flush_pend) begin
          r_valid <= '0;
        end else begin
          r_valid[r_fill_idx] <= 1'b1;
        end
      end
    end
  end

  // Storage arrays carry no reset; valid bits alone decide whether contents are used.
  always_ff @(posedge i_clock) begin
    if (!i_reset && w_beat) begin
      r_data[r_fill_idx][r_cnt] <= i_mem_rdata;
    end
    if (!i_reset && w_last) begin
      r_tag[r_fill_idx] <= r_fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_l1.sv
// Bench for icache_l1: directed scenarios then random traffic against a line-level reference model.
module tb_icache_l1;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_addr = '0;
  logic        i_rd = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] o_inst;
  logic        o_hit;
  logic        o_busy;
  logic [31:0] o_mem_addr;
  logic        o_mem_rd;
  logic [31:0] i_mem_rdata = '0;
  logic        i_mem_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-line valid/tag plus the refill in progress.
  bit          m_valid [128];
  logic [20:0] m_tag   [128];
  bit          m_fill;
  bit          m_pend;
  int          m_cnt;
  logic [31:0] m_base;

  icache_l1 dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_addr     (i_addr),
    .i_rd       (i_rd),
    .i_flush    (i_flush),
    .o_inst     (o_inst),
    .o_hit      (o_hit),
    .o_busy     (o_busy),
    .o_mem_addr (o_mem_addr),
    .o_mem_rd   (o_mem_rd),
    .i_mem_rdata(i_mem_rdata),
    .i_mem_ready(i_mem_ready)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 128; k++) m_valid[k] = 1'b0;
    m_fill = 1'b0;
    m_pend = 1'b0;
    m_cnt  = 0;
  endtask

  // One clock: drive after the edge, compare at the falling edge, then advance the model.
  task automatic cyc(input logic rst, input logic rd, input logic [31:0] addr,
                     input logic fl, input logic rdy);
    int          idx;
    logic [20:0] tg;
    bit          e_hit;
    logic [31:0] e_maddr;
    @(posedge i_clock);
    #1;
    i_reset     = rst;
    i_rd        = rd;
    i_addr      = addr;
    i_flush     = fl;
    i_mem_ready = rdy;
    i_mem_rdata = (rdy && o_mem_rd) ? mem_word(o_mem_addr) : $urandom;
    @(negedge i_clock);
    idx     = int'((addr >> 4) % 128);
    tg      = 21'(addr >> 11);
    e_hit   = !m_fill && rd && !fl && m_valid[idx] && (m_tag[idx] == tg);
    e_maddr = m_fill ? m_base + 32'(m_cnt * 4) : 32'h0;
    check("busy", 64'(o_busy), 64'(m_fill));
    check("mem_rd", 64'(o_mem_rd), 64'(m_fill));
    check("mem_addr", 64'(o_mem_addr), 64'(e_maddr));
    if (!rst) begin
      check("hit", 64'(o_hit), 64'(e_hit));
      if (e_hit) check("inst", 64'(o_inst), 64'(mem_word(addr)));
    end
    if (rst) begin
      model_reset();
    end else if (!m_fill) begin
      if (fl) begin
        for (int k = 0; k < 128; k++) m_valid[k] = 1'b0;
      end else if (rd && !e_hit) begin
        m_fill = 1'b1;
        m_base = addr & 32'hFFFF_FFF0;
        m_cnt  = 0;
      end
    end else begin
      if (fl) m_pend = 1'b1;
      if (rdy) begin
        m_cnt++;
        if (m_cnt == 4) begin
          idx = int'((m_base >> 4) % 128);
          if (m_pend) begin
            for (int k = 0; k < 128; k++) m_valid[k] = 1'b0;
          end else begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = 21'(m_base >> 11);
          end
          m_fill = 1'b0;
          m_pend = 1'b0;
          m_cnt  = 0;
        end
      end
    end
  endtask

  // Completes the current refill with memory answering every third cycle; fetch inputs are junk.
  task automatic fill_wait();
    int n;
    n = 0;
    while (m_fill && n < 200) begin
      cyc(1'b0, 1'b1, $urandom, 1'b0, (n % 3) == 2);
      n++;
    end
    check("fill_done", 64'(m_fill), 64'(0));
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] t;
    logic [31:0] ix;
    t = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       ix = 32'h10;
      1:       ix = 32'h11;
      2:       ix = 32'h7F;
      default: ix = 32'h00;
    endcase
    return (t << 11) | (ix << 4) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    model_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h104, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Cold miss, then whole-line hits.
    cyc(1'b0, 1'b1, 32'h104, 1'b0, 1'b0);
    fill_wait();
    cyc(1'b0, 1'b1, 32'h104, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h108, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h10C, 1'b0, 1'b0);

    // Conflict on index 0x10, then original line returns.
    cyc(1'b0, 1'b1, 32'h904, 1'b0, 1'b0);
    fill_wait();
    cyc(1'b0, 1'b1, 32'h908, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h104, 1'b0, 1'b0);
    fill_wait();
    cyc(1'b0, 1'b1, 32'h104, 1'b0, 1'b0);

    // Flush in IDLE with a hitting fetch present, then flush during the 2nd word of a refill.
    cyc(1'b0, 1'b1, 32'h104, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 32'h104, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    fill_wait();
    cyc(1'b0, 1'b1, 32'h104, 1'b0, 1'b0);
    fill_wait();

    // Reset after the 2nd beat, stray ready, refetch from word 0.
    cyc(1'b0, 1'b1, 32'h1A4, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'h1A4, 1'b0, 1'b0);
    fill_wait();
    cyc(1'b0, 1'b1, 32'h1A0, 1'b0, 1'b0);

    // Memory stall for 10 cycles mid-refill.
    cyc(1'b0, 1'b1, 32'h3F8, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
    fill_wait();
    cyc(1'b0, 1'b1, 32'h3F4, 1'b0, 1'b0);

    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, rand_addr(),
          $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
